// File: rtl/regfile_scoreboard_pkg.sv
// +--------------------------------------------------------------------------+
// | regfile_scoreboard_pkg                                                   |
// | Shared sizing constants and helpers for the register-file scoreboard.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package regfile_scoreboard_pkg;

   localparam int REG_ADDR_WIDTH  = 5;
   localparam int NUM_REGISTERS   = 32;
   localparam int SB_CNT_W        = 2;
   localparam int SB_MAX_INFLIGHT = 4;

   // Largest value a pending counter of the given width can hold.
   function automatic int sb_sat_value(input int width);
      return (1 << width) - 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard_sb_slot_counter.sv
// +--------------------------------------------------------------------------+
// | sb_slot_counter                                                          |
// | Per-register pending-write counter: net-zero, saturating, underflow-safe.|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module sb_slot_counter
   import regfile_scoreboard_pkg::*;
#(
   parameter int CNT_W = SB_CNT_W
) (
   input  logic             CLK,
   input  logic             RSTn,
   input  logic             flush,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             busy,
   output logic             sat,
   output logic             underflow
);

   localparam logic [CNT_W-1:0] SAT_VAL = CNT_W'(sb_sat_value(CNT_W));

   logic dec_hit;

   assign busy      = (cnt != '0);
   assign sat       = (cnt == SAT_VAL);
   assign underflow = dec && !busy;
   assign dec_hit   = dec && busy;

   // A retiring write with nothing pending leaves the count alone.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         cnt <= '0;
      end else if (flush) begin
         cnt <= '0;
      end else if (inc && !dec_hit && !sat) begin
         cnt <= cnt + 1'b1;
      end else if (dec_hit && !inc) begin
         cnt <= cnt - 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// +--------------------------------------------------------------------------+
// | regfile_scoreboard                                                       |
// | Issue-stage RAW/WAW/capacity scheduler for the 2R/1W register file.      |
// | Optional same-cycle writeback bypass: SCOREBOARD_WB_BYPASS_EN            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module regfile_scoreboard
   import regfile_scoreboard_pkg::*;
#(
   parameter int NUM_REGS     = NUM_REGISTERS,
   parameter int CNT_W        = SB_CNT_W,
   parameter int MAX_INFLIGHT = SB_MAX_INFLIGHT
) (
   input  logic                              CLK,
   input  logic                              RSTn,
   input  logic                              flush,
   input  logic                              issue_valid,
   output logic                              issue_ready,
   input  logic [REG_ADDR_WIDTH-1:0]         issue_rs1_addr,
   input  logic [REG_ADDR_WIDTH-1:0]         issue_rs2_addr,
   input  logic                              issue_uses_rs1,
   input  logic                              issue_uses_rs2,
   input  logic [REG_ADDR_WIDTH-1:0]         issue_rd_addr,
   input  logic                              issue_rd_we,
   input  logic                              wb_valid,
   input  logic [REG_ADDR_WIDTH-1:0]         wb_rd_addr,
   output logic                              rf_read_enable,
   output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight_cnt,
   output logic                              underflow_err
`ifdef SCOREBOARD_WB_BYPASS_EN
   ,
   output logic                              fwd_rs1_sel,
   output logic                              fwd_rs2_sel
`endif
);

   localparam int                INFL_W   = $clog2(MAX_INFLIGHT + 1);
   localparam logic [INFL_W-1:0] INFL_MAX = INFL_W'(MAX_INFLIGHT);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

   logic [CNT_W-1:0]    cnt [NUM_REGS];
   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] sat;
   logic [NUM_REGS-1:0] underflow;

   logic wb_live;
   logic wb_retire;
   logic fire;
   logic alloc;
   logic rd_tracked;
   logic src1_pending;
   logic src2_pending;
   logic src1_hz;
   logic src2_hz;
   logic waw_hz;
   logic cap_hz;

   // x0 is never tracked.
   assign cnt[0]       = '0;
   assign busy[0]      = 1'b0;
   assign sat[0]       = 1'b0;
   assign underflow[0] = 1'b0;

   assign wb_live    = wb_valid && !flush && (wb_rd_addr != '0);
   assign wb_retire  = wb_live && busy[wb_rd_addr];
   assign rd_tracked = issue_rd_we && (issue_rd_addr != '0);
   assign fire       = issue_valid && issue_ready;
   assign alloc      = fire && rd_tracked;

   generate
      for (genvar i = 1; i < NUM_REGS; i++) begin : g_slot
         sb_slot_counter #(
            .CNT_W (CNT_W)
         ) u_slot (
            .CLK       (CLK),
            .RSTn      (RSTn),
            .flush     (flush),
            .inc       (alloc && (issue_rd_addr == REG_ADDR_WIDTH'(i))),
            .dec       (wb_live && (wb_rd_addr == REG_ADDR_WIDTH'(i))),
            .cnt       (cnt[i]),
            .busy      (busy[i]),
            .sat       (sat[i]),
            .underflow (underflow[i])
         );
      end
   endgenerate

   assign src1_pending = issue_uses_rs1 && (issue_rs1_addr != '0) && (cnt[issue_rs1_addr] != '0);
   assign src2_pending = issue_uses_rs2 && (issue_rs2_addr != '0) && (cnt[issue_rs2_addr] != '0);

`ifdef SCOREBOARD_WB_BYPASS_EN
   // The last outstanding write retiring this cycle can be forwarded.
   assign fwd_rs1_sel = src1_pending && wb_live && (wb_rd_addr == issue_rs1_addr)
                        && (cnt[issue_rs1_addr] == CNT_ONE);
   assign fwd_rs2_sel = src2_pending && wb_live && (wb_rd_addr == issue_rs2_addr)
                        && (cnt[issue_rs2_addr] == CNT_ONE);
   assign src1_hz     = src1_pending && !fwd_rs1_sel;
   assign src2_hz     = src2_pending && !fwd_rs2_sel;
`else
   assign src1_hz     = src1_pending;
   assign src2_hz     = src2_pending;
`endif

   assign waw_hz = rd_tracked && sat[issue_rd_addr];
   assign cap_hz = rd_tracked && (inflight_cnt == INFL_MAX);

   assign issue_ready    = RSTn && !flush && !src1_hz && !src2_hz && !waw_hz && !cap_hz;
   assign rf_read_enable = fire;

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         inflight_cnt <= '0;
      end else if (flush) begin
         inflight_cnt <= '0;
      end else begin
         case ({alloc, wb_retire})
            2'b10:   inflight_cnt <= inflight_cnt + 1'b1;
            2'b01:   inflight_cnt <= inflight_cnt - 1'b1;
            default: inflight_cnt <= inflight_cnt;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         underflow_err <= 1'b0;
      end else if (flush) begin
         underflow_err <= 1'b0;
      end else if (|underflow) begin
         underflow_err <= 1'b1;
      end
   end

`ifndef SCOREBOARD_WB_BYPASS_EN
   // CNT_ONE is only needed by the bypass comparison.
   logic unused_cnt_one;
   assign unused_cnt_one = ^CNT_ONE;
`endif

endmodule

`default_nettype wire
